rslt_stream_packer: RTL

Downstream stage of the parallelized data processor. It consumes the CHANNELS parallel per-result AXI-Stream outputs, where CHANNELS equals RSLT_CHANNELS×BATCH_SIZE. It merges them in strict channel order into one wide AXI-Stream suitable for a DMA write path, and flushes a partial beat with tlast at every packet end. A sticky error flag reports rows whose tlast bits disagree across channels.

---
 rtl/rslt_stream_packer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/rslt_stream_packer.sv
// Merges CHANNELS per-result streams, in strict channel order, into one wide
// AXI-Stream beat of OUT_WORDS words; flushes a partial beat at packet end.
module rslt_stream_packer #(
    parameter int CHANNELS   = 4,
    parameter int RSLT_WIDTH = 16,
    parameter int OUT_WORDS  = 4,
    parameter int KEEP_WIDTH = (RSLT_WIDTH + 7) / 8,
    parameter int ID_WIDTH   = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [CHANNELS*RSLT_WIDTH-1:0]   s_axis_rslt_tdata,
    input  logic [CHANNELS-1:0]              s_axis_rslt_tvalid,
    output logic [CHANNELS-1:0]              s_axis_rslt_tready,
    input  logic [CHANNELS-1:0]              s_axis_rslt_tlast,
    input  logic [CHANNELS*ID_WIDTH-1:0]     s_axis_rslt_tid,
    output logic [OUT_WORDS*RSLT_WIDTH-1:0]  m_axis_tdata,
    output logic [OUT_WORDS*KEEP_WIDTH-1:0]  m_axis_tkeep,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             m_axis_tlast,
    output logic [ID_WIDTH-1:0]              m_axis_tid,
    output logic                             err_unaligned_rslt
);

    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int SLOT_W = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;
    localparam int DATA_W = OUT_WORDS * RSLT_WIDTH;
    localparam int KEEP_W = OUT_WORDS * KEEP_WIDTH;
    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(CHANNELS - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(OUT_WORDS - 1);

    logic [CH_W-1:0]       ch_ptr_q, ch_ptr_d;
    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic [DATA_W-1:0]     pack_data_q, pack_data_d;
    logic [KEEP_W-1:0]     pack_keep_q, pack_keep_d;
    logic [ID_WIDTH-1:0]   pack_tid_q, pack_tid_d;
    logic                  row_last_q, row_last_d;
    logic [DATA_W-1:0]     out_data_q, out_data_d;
    logic [KEEP_W-1:0]     out_keep_q, out_keep_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic [ID_WIDTH-1:0]   out_tid_q, out_tid_d;
    logic                  err_q, err_d;

    logic                  out_free;
    logic                  accept;
    logic                  flush;
    logic                  cur_valid;
    logic                  cur_last;
    logic [RSLT_WIDTH-1:0] cur_data;
    logic [ID_WIDTH-1:0]   cur_id;
    logic [DATA_W-1:0]     beat_data;
    logic [KEEP_W-1:0]     beat_keep;
    logic [ID_WIDTH-1:0]   beat_tid;

    // Only the channel under ch_ptr is ever offered ready; reset forces it low too.
    always_comb begin
        out_free  = !out_valid_q || m_axis_tready;
        cur_valid = s_axis_rslt_tvalid[ch_ptr_q];
        cur_last  = s_axis_rslt_tlast[ch_ptr_q];
        cur_data  = s_axis_rslt_tdata[int'(ch_ptr_q)*RSLT_WIDTH +: RSLT_WIDTH];
        cur_id    = s_axis_rslt_tid[int'(ch_ptr_q)*ID_WIDTH +: ID_WIDTH];
        accept    = rst_n && out_free && cur_valid;
        flush     = (ch_ptr_q == LAST_CH) && cur_last;
        s_axis_rslt_tready           = '0;
        s_axis_rslt_tready[ch_ptr_q] = rst_n && out_free;
    end

    always_comb begin
        ch_ptr_d    = ch_ptr_q;
        slot_d      = slot_q;
        pack_data_d = pack_data_q;
        pack_keep_d = pack_keep_q;
        pack_tid_d  = pack_tid_q;
        row_last_d  = row_last_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_tid_d   = out_tid_q;
        err_d       = err_q;
        beat_data   = pack_data_q;
        beat_keep   = pack_keep_q;
        beat_tid    = (slot_q == '0) ? cur_id : pack_tid_q;

        beat_data[int'(slot_q)*RSLT_WIDTH +: RSLT_WIDTH] = cur_data;
        beat_keep[int'(slot_q)*KEEP_WIDTH +: KEEP_WIDTH] = '1;

        if (m_axis_tready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            ch_ptr_d = (ch_ptr_q == LAST_CH) ? '0 : ch_ptr_q + CH_W'(1);

            // Channel 0 sets the row's reference tlast; every later channel must agree.
            if (ch_ptr_q == '0) begin
                row_last_d = cur_last;
            end else if (cur_last != row_last_q) begin
                err_d = 1'b1;
            end

            if ((slot_q == LAST_SLOT) || flush) begin
                out_data_d  = beat_data;
                out_keep_d  = beat_keep;
                out_tid_d   = beat_tid;
                out_last_d  = flush;
                out_valid_d = 1'b1;
                slot_d      = '0;
                pack_data_d = '0;
                pack_keep_d = '0;
                pack_tid_d  = '0;
            end else begin
                pack_data_d = beat_data;
                pack_keep_d = beat_keep;
                pack_tid_d  = beat_tid;
                slot_d      = slot_q + SLOT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_ptr_q    <= '0;
            slot_q      <= '0;
            pack_data_q <= '0;
            pack_keep_q <= '0;
            pack_tid_q  <= '0;
            row_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_tid_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            ch_ptr_q    <= ch_ptr_d;
            slot_q      <= slot_d;
            pack_data_q <= pack_data_d;
            pack_keep_q <= pack_keep_d;
            pack_tid_q  <= pack_tid_d;
            row_last_q  <= row_last_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_tid_q   <= out_tid_d;
            err_q       <= err_d;
        end
    end

    assign m_axis_tdata       = out_data_q;
    assign m_axis_tkeep       = out_keep_q;
    assign m_axis_tvalid      = out_valid_q;
    assign m_axis_tlast       = out_last_q;
    assign m_axis_tid         = out_tid_q;
    assign err_unaligned_rslt = err_q;

endmodule
